// File: rtl/sgmii_symbol_serializer.sv
// SGMII TX lane: character FIFO, 8b/10b encoder with running disparity, 1 bit/clock serializer.
// Idle /I1/ or /I2/ sets fill empty boundaries. Define SGMII_SER_STATS_EN for the symbol counters.
module sgmii_symbol_serializer #(
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
`ifdef SGMII_SER_STATS_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic       ser_sgmii_clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_is_k,
  input  logic [7:0] in_data,
  output logic       sgmii_rx_p,
  output logic       sgmii_rx_n,
  output logic       sym_start,
  output logic       idle_active,
  output logic       disp_out
`ifdef SGMII_SER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_data_cnt,
  output logic [CNT_WIDTH-1:0] stat_idle_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  // SEL_FIFO: no set in flight | SEL_I1: D5.6 owed | SEL_I2: D16.2 owed
  typedef enum logic [1:0] {SEL_FIFO, SEL_I1, SEL_I2} sel_e;

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]  bit_cnt_q;
  logic [8:0]  shift_q;
  logic        rx_p_q, sym_start_q, idle_active_q, rd_q;
  sel_e        pend_q, pend_d;

  logic        full, empty, push, pop, boundary, idle_start;
  logic        sym_k, sym_idle;
  logic [7:0]  sym_d;
  logic [10:0] enc;
  logic [9:0]  line_sym;

  function automatic logic [10:0] enc_8b10b(input logic is_k, input logic [7:0] d,
                                           input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       k28, a7, flip6, flip4, rd_mid, rd_out;
    x   = d[4:0];
    y   = d[7:5];
    k28 = is_k && (x == 5'd28);
    // RD- forms of the 5b/6b code, abcdei with 'a' in bit 5
    case (x)
      5'd0:    c6 = 6'b100111;
      5'd1:    c6 = 6'b011101;
      5'd2:    c6 = 6'b101101;
      5'd3:    c6 = 6'b110001;
      5'd4:    c6 = 6'b110101;
      5'd5:    c6 = 6'b101001;
      5'd6:    c6 = 6'b011001;
      5'd7:    c6 = 6'b111000;
      5'd8:    c6 = 6'b111001;
      5'd9:    c6 = 6'b100101;
      5'd10:   c6 = 6'b010101;
      5'd11:   c6 = 6'b110100;
      5'd12:   c6 = 6'b001101;
      5'd13:   c6 = 6'b101100;
      5'd14:   c6 = 6'b011100;
      5'd15:   c6 = 6'b010111;
      5'd16:   c6 = 6'b011011;
      5'd17:   c6 = 6'b100011;
      5'd18:   c6 = 6'b010011;
      5'd19:   c6 = 6'b110010;
      5'd20:   c6 = 6'b001011;
      5'd21:   c6 = 6'b101010;
      5'd22:   c6 = 6'b011010;
      5'd23:   c6 = 6'b111010;
      5'd24:   c6 = 6'b110011;
      5'd25:   c6 = 6'b100110;
      5'd26:   c6 = 6'b010110;
      5'd27:   c6 = 6'b110110;
      5'd28:   c6 = 6'b001110;
      5'd29:   c6 = 6'b101110;
      5'd30:   c6 = 6'b011110;
      default: c6 = 6'b101011;
    endcase
    if (k28) c6 = 6'b001111;
    flip6 = ($countones(c6) != 3);
    if (rd_in && (flip6 || x == 5'd7)) c6 = ~c6;
    rd_mid = rd_in ^ flip6;

    a7 = (y == 3'd7) && (is_k ||
         (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
         ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    case (y)
      3'd0:    c4 = 4'b1011;
      3'd1:    c4 = k28 ? 4'b0110 : 4'b1001;
      3'd2:    c4 = k28 ? 4'b1010 : 4'b0101;
      3'd3:    c4 = 4'b1100;
      3'd4:    c4 = 4'b1101;
      3'd5:    c4 = k28 ? 4'b0101 : 4'b1010;
      3'd6:    c4 = k28 ? 4'b1001 : 4'b0110;
      default: c4 = a7 ? 4'b0111 : 4'b1110;
    endcase
    flip4 = ($countones(c4) != 2);
    if (rd_mid && (flip4 || y == 3'd3 || k28)) c4 = ~c4;
    rd_out = rd_mid ^ flip4;
    return {rd_out, c6, c4};
  endfunction

  assign full     = (wr_ptr_q == (rd_ptr_q ^ FULL_XOR));
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign in_ready = ~full & ~reset;
  assign push     = in_valid & in_ready;
  assign boundary = (bit_cnt_q == 4'd9);

  always_comb begin
    sym_k    = 1'b1;
    sym_d    = 8'hBC;
    sym_idle = 1'b1;
    pop      = 1'b0;
    pend_d   = SEL_FIFO;
    case (pend_q)
      SEL_I1: begin
        sym_k = 1'b0;
        sym_d = 8'hC5;
      end
      SEL_I2: begin
        sym_k = 1'b0;
        sym_d = 8'h50;
      end
      default: begin
        if (!empty) begin
          {sym_k, sym_d} = mem_q[rd_ptr_q[AW-1:0]];
          sym_idle       = 1'b0;
          pop            = boundary;
        end else begin
          pend_d = rd_q ? SEL_I1 : SEL_I2;
        end
      end
    endcase
  end

  assign idle_start = boundary & (pend_q == SEL_FIFO) & empty;
  assign enc        = enc_8b10b(sym_k, sym_d, rd_q);

  // line_sym[0] always leaves first, so bit order is fixed here once
  always_comb begin
    line_sym = '0;
    for (int i = 0; i < 10; i++) begin
      line_sym[i] = (MSB_FIRST != 0) ? enc[9-i] : enc[i];
    end
  end

  always_ff @(posedge ser_sgmii_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_is_k, in_data};
  end

  always_ff @(posedge ser_sgmii_clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      bit_cnt_q     <= 4'd9;
      shift_q       <= '0;
      rx_p_q        <= 1'b1;
      sym_start_q   <= 1'b0;
      idle_active_q <= 1'b0;
      rd_q          <= 1'b0;
      pend_q        <= SEL_FIFO;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (boundary) begin
        bit_cnt_q     <= 4'd0;
        {shift_q, rx_p_q} <= line_sym;
        sym_start_q   <= 1'b1;
        idle_active_q <= sym_idle;
        rd_q          <= enc[10];
        pend_q        <= pend_d;
      end else begin
        bit_cnt_q   <= bit_cnt_q + 4'd1;
        rx_p_q      <= shift_q[0];
        shift_q     <= {1'b0, shift_q[8:1]};
        sym_start_q <= 1'b0;
      end
    end
  end

`ifdef SGMII_SER_STATS_EN
  logic [CNT_WIDTH-1:0] stat_data_q, stat_idle_q;

  always_ff @(posedge ser_sgmii_clk) begin
    if (reset) begin
      stat_data_q <= '0;
      stat_idle_q <= '0;
    end else begin
      if (pop)        stat_data_q <= stat_data_q + CNT_WIDTH'(1);
      if (idle_start) stat_idle_q <= stat_idle_q + CNT_WIDTH'(1);
    end
  end

  assign stat_data_cnt = stat_data_q;
  assign stat_idle_cnt = stat_idle_q;
`endif

  assign sgmii_rx_p  = rx_p_q;
  assign sgmii_rx_n  = ~rx_p_q;
  assign sym_start   = sym_start_q;
  assign idle_active = idle_active_q;
  assign disp_out    = rd_q;

endmodule

// File: tb/tb_sgmii_symbol_serializer.sv
// Directed bench for sgmii_symbol_serializer: hand-encoded 8b/10b symbols compared bit by bit.
module tb_sgmii_symbol_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_is_k = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, sgmii_rx_p, sgmii_rx_n, sym_start, idle_active, disp_out;
`ifdef SGMII_SER_STATS_EN
  logic [15:0] stat_data_cnt, stat_idle_cnt;
`endif

  int         checks = 0;
  int         errors = 0;
  logic       saw_full = 1'b0;
  logic [8:0] wq[$];

  sgmii_symbol_serializer #(.DEPTH(4), .MSB_FIRST(1)) dut (
    .ser_sgmii_clk(clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_k      (in_is_k),
    .in_data      (in_data),
    .sgmii_rx_p   (sgmii_rx_p),
    .sgmii_rx_n   (sgmii_rx_n),
    .sym_start    (sym_start),
    .idle_active  (idle_active),
    .disp_out     (disp_out)
`ifdef SGMII_SER_STATS_EN
    ,
    .stat_data_cnt(stat_data_cnt),
    .stat_idle_cnt(stat_idle_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "bench did not complete");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic collect(input string tag, input logic [9:0] exp_sym, input logic exp_idle,
                         input logic exp_disp);
    logic [9:0] got;
    logic       ss0, idle0, disp0, ss_rest, n_ok;
    got = '0; ss0 = 1'b0; idle0 = 1'b0; disp0 = 1'b0; ss_rest = 1'b0; n_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      got[9-k] = sgmii_rx_p;
      if (sgmii_rx_n !== ~sgmii_rx_p) n_ok = 1'b0;
      if (k == 0) begin
        ss0   = sym_start;
        idle0 = idle_active;
        disp0 = disp_out;
      end else if (sym_start !== 1'b0) begin
        ss_rest = 1'b1;
      end
    end
    chk({tag, "_bits"},      16'(got),            16'(exp_sym));
    chk({tag, "_sym_start"}, 16'({ss0, ss_rest}), 16'b10);
    chk({tag, "_idle"},      16'(idle0),          16'(exp_idle));
    chk({tag, "_disp"},      16'(disp0),          16'(exp_disp));
    chk({tag, "_rx_n"},      16'(n_ok),           16'(1'b1));
  endtask

  task automatic writer(input int delay);
    int   guard;
    logic acc;
    guard = 0;
    repeat (delay) @(negedge clk);
    while (wq.size() != 0 && guard < 400) begin
      {in_is_k, in_data} = wq[0];
      in_valid = 1'b1;
      acc = in_ready;
      if (!in_ready) saw_full = 1'b1;
      @(negedge clk);
      if (acc) void'(wq.pop_front());
      guard++;
    end
    in_valid = 1'b0;
    chk("writer_drain", 16'(wq.size()), 16'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rx_p",     16'(sgmii_rx_p),  16'(1'b1));
    chk("rst_rx_n",     16'(sgmii_rx_n),  16'(1'b0));
    chk("rst_sym_start",16'(sym_start),   16'(1'b0));
    chk("rst_idle",     16'(idle_active), 16'(1'b0));
    chk("rst_disp",     16'(disp_out),    16'(1'b0));
    chk("rst_in_ready", 16'(in_ready),    16'(1'b0));
    reset = 1'b0;

    // idle /I2/ straight out of reset
    collect("i2_k285", 10'b0011111010, 1'b1, 1'b1);
    collect("i2_d162", 10'b1001000101, 1'b1, 1'b0);
    chk("in_ready_after_rst", 16'(in_ready), 16'(1'b1));

    // D28.5 written during K28.5 must wait for the D16.2
    wq.push_back({1'b0, 8'hBC});
    fork
      writer(3);
      begin
        collect("nosplit_k285", 10'b0011111010, 1'b1, 1'b1);
        collect("nosplit_d162", 10'b1001000101, 1'b1, 1'b0);
        collect("d285",         10'b0011101010, 1'b0, 1'b0);
      end
    join

    // D3.0 leaves RD+, so the following set is /I1/
    wq.push_back({1'b0, 8'h03});
    fork
      writer(3);
      begin
        collect("pre_k285",  10'b0011111010, 1'b1, 1'b1);
        collect("pre_d162",  10'b1001000101, 1'b1, 1'b0);
        collect("d30",       10'b1100011011, 1'b0, 1'b1);
        collect("i1_k285p",  10'b1100000101, 1'b1, 1'b0);
        collect("i1_d56",    10'b1010010110, 1'b1, 1'b0);
      end
    join

    // back-to-back stream: FIFO fills, order kept, alternate-7 and K paths
    wq.push_back({1'b0, 8'hB5});
    wq.push_back({1'b1, 8'hBC});
    wq.push_back({1'b0, 8'h00});
    wq.push_back({1'b0, 8'hE7});
    wq.push_back({1'b0, 8'hF1});
    wq.push_back({1'b0, 8'hEB});
    wq.push_back({1'b1, 8'hFC});
    wq.push_back({1'b0, 8'h63});
    fork
      writer(0);
      begin
        collect("st_k285", 10'b0011111010, 1'b1, 1'b1);
        collect("st_d162", 10'b1001000101, 1'b1, 1'b0);
        collect("st_d215", 10'b1010101010, 1'b0, 1'b0);
        collect("st_k285d",10'b0011111010, 1'b0, 1'b1);
        collect("st_d00",  10'b0110001011, 1'b0, 1'b1);
        collect("st_d77",  10'b0001110001, 1'b0, 1'b0);
        collect("st_d177", 10'b1000110111, 1'b0, 1'b1);
        collect("st_d117", 10'b1101001000, 1'b0, 1'b0);
        collect("st_k287", 10'b0011111000, 1'b0, 1'b0);
        collect("st_d33",  10'b1100011100, 1'b0, 1'b0);
      end
    join
    chk("stream_saw_full", 16'(saw_full), 16'(1'b1));
    chk("stream_ready",    16'(in_ready), 16'(1'b1));

    // reset in the middle of D21.5 sent at RD+, with two characters still queued
    wq.push_back({1'b0, 8'h03});
    wq.push_back({1'b0, 8'hB5});
    wq.push_back({1'b0, 8'hB5});
    wq.push_back({1'b0, 8'hB5});
    fork
      writer(3);
      begin
        collect("mr_k285", 10'b0011111010, 1'b1, 1'b1);
        collect("mr_d162", 10'b1001000101, 1'b1, 1'b0);
        collect("mr_d30",  10'b1100011011, 1'b0, 1'b1);
      end
    join
    repeat (6) @(negedge clk);
    chk("mr_bit5", 16'(sgmii_rx_p), 16'(1'b0));
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rx_p",      16'(sgmii_rx_p),  16'(1'b1));
    chk("mr_rx_n",      16'(sgmii_rx_n),  16'(1'b0));
    chk("mr_sym_start", 16'(sym_start),   16'(1'b0));
    chk("mr_in_ready",  16'(in_ready),    16'(1'b0));
    chk("mr_disp",      16'(disp_out),    16'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    collect("post_k285", 10'b0011111010, 1'b1, 1'b1);
    collect("post_d162", 10'b1001000101, 1'b1, 1'b0);

    // FIFO was flushed: another idle set, then three data characters
    wq.push_back({1'b0, 8'hB5});
    wq.push_back({1'b0, 8'hB5});
    wq.push_back({1'b0, 8'hB5});
    fork
      writer(3);
      begin
        collect("post2_k285", 10'b0011111010, 1'b1, 1'b1);
        collect("post2_d162", 10'b1001000101, 1'b1, 1'b0);
        collect("three_a",    10'b1010101010, 1'b0, 1'b0);
        collect("three_b",    10'b1010101010, 1'b0, 1'b0);
        collect("three_c",    10'b1010101010, 1'b0, 1'b0);
        collect("tail_k285",  10'b0011111010, 1'b1, 1'b1);
      end
    join
`ifdef SGMII_SER_STATS_EN
    chk("stat_data", stat_data_cnt, 16'd3);
    chk("stat_idle", stat_idle_cnt, 16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
